// File: rtl/imem_pkg.sv
// Shared encodings for the instruction-memory fetch block: response fault
// codes, the NOP word substituted into faulted responses, and the fetch
// FSM state encoding.
package imem_pkg;

  // Fault classification carried alongside every response.
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_code_e;

  // IDLE: nothing held. RESP: one response held on the output.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } fetch_state_e;

  // addi x0, x0, 0 -- returned in place of data on any fault.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A byte address is usable as a word address only when its low two bits are clear.
  function automatic logic is_misaligned(input logic [1:0] byte_lsb);
    return (byte_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous read port, one write port.
// A read and a write to the same word in the same cycle return the word's
// previous contents. Contents are never cleared.
module imem_ram #(
  parameter  int depth_words = 256,
  parameter  int instr_width = 32,
  localparam int idx_w       = $clog2(depth_words)
) (
  input  logic                   clk,
  input  logic                   rd_en,
  input  logic [idx_w-1:0]       rd_idx,
  output logic [instr_width-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [idx_w-1:0]       wr_idx,
  input  logic [instr_width-1:0] wr_data
);

  logic [instr_width-1:0] mem [depth_words];

  // Write port; the array update lands after this edge's read, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read port; rd_data holds its value between enabled reads so a held response stays stable.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/imem_fetch_resp.sv
// Instruction-memory fetch/response stage.
// Accepts a byte-addressed fetch request, returns the instruction word one
// cycle later and holds it until the consumer takes it or a flush drops it.
// Misaligned requests return a NOP with a fault flag.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN -- when defined, addresses at
// or beyond the end of storage fault with the range code instead of wrapping.
module imem_fetch_resp
  import imem_pkg::*;
#(
  parameter int pc_width    = 32,
  parameter int instr_width = 32,
  parameter int depth_words = 256
) (
  input  logic                   clk_150_mhz,
  input  logic                   imem_rst,
  input  logic                   addr_valid,
  input  logic [pc_width-1:0]    instr_addr,
  output logic                   addr_ready,
  input  logic                   flush,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [instr_width-1:0] instr_data,
  output logic [pc_width-1:0]    instr_pc,
  output logic                   fetch_fault,
  output logic [1:0]             fault_code,
  input  logic                   wr_en,
  input  logic [pc_width-1:0]    wr_addr,
  input  logic [instr_width-1:0] wr_data
);

  localparam int idx_w = $clog2(depth_words);
  localparam logic [instr_width-1:0] nop_word = instr_width'(NOP_INSTR);

`ifdef IMEM_BOUNDS_CHECK_EN
  // One bit wider than the address so the byte limit itself cannot overflow.
  localparam logic [pc_width:0] addr_limit = (pc_width+1)'(64'(depth_words) * 64'd4);
`endif

  fetch_state_e           state_p1;
  logic                   vld_p1;
  logic [pc_width-1:0]    pc_p1;
  logic                   fault_p1;
  fault_code_e            code_p1;

  fault_code_e            code_p0;
  logic                   accept_p0;
  logic                   wr_ok;
  logic [instr_width-1:0] ram_q_p1;
  logic                   wr_addr_unused;

  // ---- stage p0: request classification and handshake ----

  // A held response frees the slot when consumed or flushed; reset blocks acceptance.
  always_comb begin
    addr_ready = 1'b0;
    if (!imem_rst) begin
      addr_ready = (state_p1 == ST_IDLE) ||
                   ((state_p1 == ST_RESP) && instr_ready) ||
                   flush;
    end
  end

  assign accept_p0 = addr_valid && addr_ready;

  // Misalignment outranks the range check.
  always_comb begin
    code_p0 = FAULT_NONE;
    if (is_misaligned(instr_addr[1:0])) begin
      code_p0 = FAULT_MISALIGN;
    end
`ifdef IMEM_BOUNDS_CHECK_EN
    else if ({1'b0, instr_addr} >= addr_limit) begin
      code_p0 = FAULT_RANGE;
    end
`endif
  end

  // Program-load writes must be word aligned; misaligned ones are dropped.
  assign wr_ok = wr_en && !is_misaligned(wr_addr[1:0]);

  // Upper write-address bits beyond the storage index wrap and are otherwise unused.
  assign wr_addr_unused = ^wr_addr;

  imem_ram #(
    .depth_words (depth_words),
    .instr_width (instr_width)
  ) u_ram (
    .clk     (clk_150_mhz),
    .rd_en   (accept_p0),
    .rd_idx  (instr_addr[idx_w+1:2]),
    .rd_data (ram_q_p1),
    .wr_en   (wr_ok),
    .wr_idx  (wr_addr[idx_w+1:2]),
    .wr_data (wr_data)
  );

  // ---- stage p1: held response ----

  // Fetch FSM: a new accept always wins (covers flush+accept); otherwise consume/flush empties the slot.
  always_ff @(posedge clk_150_mhz) begin
    if (imem_rst) begin
      state_p1 <= ST_IDLE;
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      fault_p1 <= 1'b0;
      code_p1  <= FAULT_NONE;
    end else begin
      case (state_p1)
        ST_IDLE: begin
          if (accept_p0) begin
            state_p1 <= ST_RESP;
            vld_p1   <= 1'b1;
            pc_p1    <= instr_addr;
            fault_p1 <= (code_p0 != FAULT_NONE);
            code_p1  <= code_p0;
          end
        end
        ST_RESP: begin
          if (accept_p0) begin
            state_p1 <= ST_RESP;
            vld_p1   <= 1'b1;
            pc_p1    <= instr_addr;
            fault_p1 <= (code_p0 != FAULT_NONE);
            code_p1  <= code_p0;
          end else if (instr_ready || flush) begin
            state_p1 <= ST_IDLE;
            vld_p1   <= 1'b0;
          end
        end
        default: begin
          state_p1 <= ST_IDLE;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  // Faulted responses carry a NOP; with nothing held the data bus reads zero.
  always_comb begin
    instr_data = '0;
    if (vld_p1) begin
      instr_data = fault_p1 ? nop_word : ram_q_p1;
    end
  end

  assign instr_valid = vld_p1;
  assign instr_pc    = pc_p1;
  assign fetch_fault = fault_p1;
  assign fault_code  = code_p1;

endmodule

// File: doc/imem_fetch_resp.md
IMEM_FETCH_RESP -- requirements
Module: imem_fetch_resp

Interface
REQ-001 SHALL have parameter pc_width, default 32, width of instruction address.
REQ-002 SHALL have parameter instr_width, default 32, width of instruction word.
REQ-003 SHALL have parameter depth_words, default 256, number of instruction words stored (power of two).
REQ-004 SHALL have port clk_150_mhz  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port imem_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr_valid  input  1  fetch request present.
REQ-007 SHALL have port instr_addr  input  pc_width  byte address of requested instruction.
REQ-008 SHALL have port addr_ready  output  1  request accepted this cycle when addr_valid also high.
REQ-009 SHALL have port flush  input  1  discard held response (taken jump).
REQ-010 SHALL have port instr_valid  output  1  response present.
REQ-011 SHALL have port instr_ready  input  1  consumer takes response.
REQ-012 SHALL have port instr_data  output  instr_width  fetched instruction word.
REQ-013 SHALL have port instr_pc  output  pc_width  address that produced instr_data.
REQ-014 SHALL have port fetch_fault  output  1  response is a fault.
REQ-015 SHALL have port fault_code  output  2  00 none, 01 misaligned, 10 out of range.
REQ-016 SHALL have ports wr_en  input  1, wr_addr  input  pc_width, wr_data  input  instr_width: program-load write port (byte address, word aligned).

Function
REQ-017 SHALL implement states IDLE (no response held) and RESP (response held, instr_valid=1).
REQ-018 SHALL drive addr_ready = (state==IDLE) or (state==RESP and instr_ready) or flush.
REQ-019 SHALL, on accept, enter RESP next cycle with registered instr_data/instr_pc; latency exactly 1 cycle.
REQ-020 SHALL hold instr_data, instr_pc, fetch_fault, fault_code stable while instr_valid=1 and instr_ready=0.
REQ-021 SHALL return to IDLE when response consumed or flushed and no new accept occurs same cycle.
REQ-022 SHALL, on flush with simultaneous accept, drop the held response and present the new one next cycle.
REQ-023 SHALL treat instr_addr[1:0]!=0 as misaligned: fetch_fault=1, fault_code=01, instr_data=32'h00000013 (NOP).
REQ-024 SHALL index memory with instr_addr[log2(depth_words)+1:2].
REQ-025 SHALL, on wr_en, write wr_data to word wr_addr[log2(depth_words)+1:2]; a read of the same word in the same cycle SHALL return old data.
REQ-026 SHALL ignore wr_en when wr_addr[1:0]!=0.

Reset
REQ-027 SHALL, on imem_rst, enter IDLE: instr_valid=0, instr_data=0, instr_pc=0, fetch_fault=0, fault_code=00; addr_ready=0 during reset cycle.
REQ-028 SHALL discard any held response when reset asserts mid-operation; memory contents are not cleared.

Configuration
REQ-029 SHALL, with macro IMEM_BOUNDS_CHECK_EN defined, flag instr_addr >= 4*depth_words as fetch_fault=1, fault_code=10, instr_data=NOP; misaligned takes priority.
REQ-030 SHALL, without IMEM_BOUNDS_CHECK_EN, wrap out-of-range addresses modulo depth_words with no fault; code 10 never produced.

Structure
REQ-031 SHALL place fault_code encodings, NOP constant and state encodings in shared package imem_pkg.
REQ-032 SHALL implement storage in sub-module imem_ram (one sync read port, one write port, read-old-on-collision).

Verification
REQ-033 SHALL cover: load word 3 = 32'h00500093 via wr_en, request addr 0x0C -> next cycle instr_valid=1, instr_data=32'h00500093, instr_pc=0x0C.
REQ-034 SHALL cover: instr_ready=0 for 3 cycles holding addr 0x0C response -> outputs unchanged, addr_ready=0; instr_ready=1 -> consumed, IDLE.
REQ-035 SHALL cover: request 0x06 -> fetch_fault=1, fault_code=01, instr_data=32'h00000013.
REQ-036 SHALL cover: depth_words=256, request 0x400 -> with IMEM_BOUNDS_CHECK_EN fault_code=10; without, returns word 0.
REQ-037 SHALL cover: held response for 0x10, flush with new request 0x20 same cycle -> next cycle instr_pc=0x20, 0x10 never consumed.
REQ-038 SHALL cover: imem_rst during RESP -> next cycle instr_valid=0, all outputs zero, memory word 3 still 32'h00500093.
